// File: rtl/wb_forward_pipe.sv
// wb_forward_pipe
// Tracks destination registers through EX, MEM and WB, drives the register
// file's forwarding (warp) ports and write port, and raises the decode stall
// for load-use hazards and data-memory wait states.
//
// Build option: define WB_LOAD_FWD_EN to forward load data out of MEM.
// Without it, MEM-stage loads never forward and a dependent instruction is
// held until the load reaches WB (two stall cycles instead of one).
module wb_forward_pipe #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_dest,
    input  logic          iss_reg_write,
    input  logic          iss_is_load,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic [DW-1:0] alu_result,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_wait,
    output logic          stall,
    output logic [AW-1:0] warp_Add_ALU,
    output logic [AW-1:0] warp_Add_MEM,
    output logic [DW-1:0] warp_ALU,
    output logic [DW-1:0] warp_MEM,
    output logic          warp_ALU_enable,
    output logic          warp_MEM_enable,
    output logic [AW-1:0] add_C,
    output logic [DW-1:0] data_C,
    output logic          write_enable
);

    // EX stage
    logic          ex_valid;
    logic          ex_regw;
    logic          ex_load;
    logic [AW-1:0] ex_dest;

    // MEM stage
    logic          mem_valid;
    logic          mem_regw;
    logic          mem_load;
    logic [AW-1:0] mem_dest;
    logic [DW-1:0] mem_alu;

    // WB stage (regw already folded into valid when it is loaded)
    logic          wb_valid;
    logic [AW-1:0] wb_dest;
    logic [DW-1:0] wb_data;

    logic          ex_live;
    logic          mem_live;
    logic          wb_live;
    logic [DW-1:0] mem_value;
    logic          ex_rs_hit;
    logic          ex_rt_hit;
    logic          ex_hazard;
    logic          mem_hazard;
    logic          stall_int;
    logic          issue_take;
    logic          ex_fwd_ok;
    logic          mem_fwd_ok;

    // Liveness, hazard detection and the value leaving MEM
    always_comb begin
        ex_live   = ex_valid  && ex_regw  && (ex_dest  != '0);
        mem_live  = mem_valid && mem_regw && (mem_dest != '0);
        wb_live   = wb_valid  && (wb_dest != '0);
        mem_value = mem_load ? mem_rdata : mem_alu;

        ex_rs_hit = id_use_rs && (id_rs == ex_dest);
        ex_rt_hit = id_use_rt && (id_rt == ex_dest);
        ex_hazard = ex_live && ex_load && (ex_rs_hit || ex_rt_hit);

`ifdef WB_LOAD_FWD_EN
        mem_hazard = 1'b0;
        mem_fwd_ok = mem_live;
`else
        // Load data is not bypassed out of MEM, so a dependent instruction
        // must also wait while the load sits in MEM.
        mem_hazard = mem_live && mem_load &&
                     ((id_use_rs && (id_rs == mem_dest)) ||
                      (id_use_rt && (id_rt == mem_dest)));
        mem_fwd_ok = mem_live && !mem_load;
`endif

        // A load in EX has no data yet; it forwards later from MEM.
        ex_fwd_ok  = ex_live && !ex_load;

        // Freeze dominates; the hazard terms are simply re-evaluated once
        // mem_wait drops because the stage registers held their contents.
        stall_int  = mem_wait || ex_hazard || mem_hazard;
        issue_take = iss_valid && !stall_int;
    end

    // EX stage register: capture issue or insert a bubble, hold on mem_wait
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid <= 1'b0;
            ex_regw  <= 1'b0;
            ex_load  <= 1'b0;
            ex_dest  <= '0;
        end else if (!mem_wait) begin
            if (issue_take) begin
                ex_valid <= 1'b1;
                ex_regw  <= iss_reg_write;
                ex_load  <= iss_is_load;
                ex_dest  <= iss_dest;
            end else begin
                ex_valid <= 1'b0;
                ex_regw  <= 1'b0;
                ex_load  <= 1'b0;
                ex_dest  <= '0;
            end
        end
    end

    // MEM stage register: take EX and latch the ALU result, hold on mem_wait
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_valid <= 1'b0;
            mem_regw  <= 1'b0;
            mem_load  <= 1'b0;
            mem_dest  <= '0;
            mem_alu   <= '0;
        end else if (!mem_wait) begin
            mem_valid <= ex_valid;
            mem_regw  <= ex_regw;
            mem_load  <= ex_load;
            mem_dest  <= ex_dest;
            mem_alu   <= alu_result;
        end
    end

    // WB stage register: take MEM with the selected load/ALU value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid <= 1'b0;
            wb_dest  <= '0;
            wb_data  <= '0;
        end else if (!mem_wait) begin
            wb_valid <= mem_valid && mem_regw;
            wb_dest  <= mem_dest;
            wb_data  <= mem_value;
        end
    end

    // Output drive; everything reads 0 while reset is held, including the
    // paths that are combinational from alu_result, mem_rdata and mem_wait.
    always_comb begin
        stall           = 1'b0;
        warp_Add_ALU    = '0;
        warp_ALU        = '0;
        warp_ALU_enable = 1'b0;
        warp_Add_MEM    = '0;
        warp_MEM        = '0;
        warp_MEM_enable = 1'b0;
        add_C           = '0;
        data_C          = '0;
        write_enable    = 1'b0;
        if (reset) begin
            stall           = stall_int;
            warp_Add_ALU    = ex_dest;
            warp_ALU        = alu_result;
            warp_ALU_enable = ex_fwd_ok;
            warp_Add_MEM    = mem_dest;
            warp_MEM        = mem_value;
            warp_MEM_enable = mem_fwd_ok;
            add_C           = wb_dest;
            data_C          = wb_data;
            write_enable    = wb_live;
        end
    end

endmodule

// File: tb/tb_wb_forward_pipe.sv
// Directed bench for wb_forward_pipe. Inputs change 1ns after the rising
// edge, outputs are compared 2ns later, well clear of either edge.
module tb_wb_forward_pipe;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          reset;
    logic          iss_valid;
    logic [AW-1:0] iss_dest;
    logic          iss_reg_write;
    logic          iss_is_load;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] mem_rdata;
    logic          mem_wait;
    logic          stall;
    logic [AW-1:0] warp_Add_ALU;
    logic [AW-1:0] warp_Add_MEM;
    logic [DW-1:0] warp_ALU;
    logic [DW-1:0] warp_MEM;
    logic          warp_ALU_enable;
    logic          warp_MEM_enable;
    logic [AW-1:0] add_C;
    logic [DW-1:0] data_C;
    logic          write_enable;

    int total;
    int bad;

    wb_forward_pipe #(.DW(DW), .AW(AW)) dut (
        .clk             (clk),
        .reset           (reset),
        .iss_valid       (iss_valid),
        .iss_dest        (iss_dest),
        .iss_reg_write   (iss_reg_write),
        .iss_is_load     (iss_is_load),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .alu_result      (alu_result),
        .mem_rdata       (mem_rdata),
        .mem_wait        (mem_wait),
        .stall           (stall),
        .warp_Add_ALU    (warp_Add_ALU),
        .warp_Add_MEM    (warp_Add_MEM),
        .warp_ALU        (warp_ALU),
        .warp_MEM        (warp_MEM),
        .warp_ALU_enable (warp_ALU_enable),
        .warp_MEM_enable (warp_MEM_enable),
        .add_C           (add_C),
        .data_C          (data_C),
        .write_enable    (write_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid     = 1'b0;
        iss_dest      = '0;
        iss_reg_write = 1'b0;
        iss_is_load   = 1'b0;
        id_rs         = '0;
        id_rt         = '0;
        id_use_rs     = 1'b0;
        id_use_rt     = 1'b0;
        mem_wait      = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] d, input logic ld);
        iss_valid     = 1'b1;
        iss_dest      = d;
        iss_reg_write = 1'b1;
        iss_is_load   = ld;
    endtask

    task automatic flush();
        idle();
        repeat (4) step();
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b0;
        alu_result = '0;
        mem_rdata  = '0;
        idle();

        // ---- power-on reset: outputs 0 even with mem_wait and issue high
        mem_wait = 1'b1;
        issue(5'd4, 1'b0);
        #2;
        chk("por_stall", stall, 0);
        chk("por_we", write_enable, 0);
        chk("por_alu_en", warp_ALU_enable, 0);
        step();
        idle();
        reset = 1'b1;

        // ---- add r5, alu=0x11 through all stages
        issue(5'd5, 1'b0);
        step();
        idle();
        alu_result = 32'h11;
        #2;
        chk("add_ex_en", warp_ALU_enable, 1);
        chk("add_ex_addr", warp_Add_ALU, 5);
        chk("add_ex_data", warp_ALU, 32'h11);
        chk("add_ex_we", write_enable, 0);
        step();
        alu_result = 32'h99;
        #2;
        chk("add_mem_en", warp_MEM_enable, 1);
        chk("add_mem_addr", warp_Add_MEM, 5);
        chk("add_mem_data", warp_MEM, 32'h11);
        chk("add_mem_ex_en", warp_ALU_enable, 0);
        step();
        #2;
        chk("add_wb_we", write_enable, 1);
        chk("add_wb_addr", add_C, 5);
        chk("add_wb_data", data_C, 32'h11);
        chk("add_wb_mem_en", warp_MEM_enable, 0);
        step();
        #2;
        chk("add_done_we", write_enable, 0);
        flush();

        // ---- load r8 then dependent reader of r8 (writes r9)
        issue(5'd8, 1'b1);
        step();
        issue(5'd9, 1'b0);
        id_rs     = 5'd8;
        id_use_rs = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        alu_result = 32'h0000_1234;
        #2;
        chk("lu_stall1", stall, 1);
        chk("lu_ex_load_no_fwd", warp_ALU_enable, 0);
        step();
        #2;
        chk("lu_ex_bubble", warp_ALU_enable, 0);
`ifdef WB_LOAD_FWD_EN
        chk("lu_stall2", stall, 0);
        chk("lu_mem_en", warp_MEM_enable, 1);
        chk("lu_mem_addr", warp_Add_MEM, 8);
        chk("lu_mem_data", warp_MEM, 32'hDEADBEEF);
        step();
`else
        chk("lu_stall2", stall, 1);
        chk("lu_mem_en_off", warp_MEM_enable, 0);
        step();
        #2;
        chk("lu_stall3", stall, 0);
        step();
`endif
        idle();
        alu_result = 32'h55;
        #2;
        chk("lu_dep_en", warp_ALU_enable, 1);
        chk("lu_dep_addr", warp_Add_ALU, 9);
`ifdef WB_LOAD_FWD_EN
        chk("lu_wb_we", write_enable, 1);
        chk("lu_wb_addr", add_C, 8);
        chk("lu_wb_data", data_C, 32'hDEADBEEF);
`endif
        flush();

        // ---- writes to r0 never enable anything
        issue(5'd0, 1'b0);
        alu_result = 32'h77;
        step();
        idle();
        #2;
        chk("r0_ex_en", warp_ALU_enable, 0);
        step();
        #2;
        chk("r0_mem_en", warp_MEM_enable, 0);
        step();
        #2;
        chk("r0_wb_we", write_enable, 0);
        flush();

        // ---- mem_wait freeze with all stages live
        issue(5'd1, 1'b0);
        step();
        issue(5'd2, 1'b0);
        alu_result = 32'hA1;
        step();
        issue(5'd3, 1'b0);
        alu_result = 32'hB2;
        step();
        issue(5'd4, 1'b0);
        alu_result = 32'hC3;
        mem_wait   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #2;
            chk("mw_stall", stall, 1);
            chk("mw_ex_addr", warp_Add_ALU, 3);
            chk("mw_mem_addr", warp_Add_MEM, 2);
            chk("mw_mem_data", warp_MEM, 32'hB2);
            chk("mw_wb_addr", add_C, 1);
            chk("mw_wb_data", data_C, 32'hA1);
            step();
        end
        mem_wait = 1'b0;
        #2;
        chk("mw_release_stall", stall, 0);
        step();
        idle();
        alu_result = 32'hD4;
        #2;
        chk("mw_adv_ex_addr", warp_Add_ALU, 4);
        chk("mw_adv_mem_addr", warp_Add_MEM, 3);
        chk("mw_adv_mem_data", warp_MEM, 32'hC3);
        chk("mw_adv_wb_addr", add_C, 2);
        chk("mw_adv_wb_data", data_C, 32'hB2);
        flush();

        // ---- load r3, decode rt=3 but rt unused
        issue(5'd3, 1'b1);
        step();
        idle();
        id_rt     = 5'd3;
        id_use_rt = 1'b0;
        id_rs     = 5'd7;
        id_use_rs = 1'b1;
        #2;
        chk("rt_unused_stall", stall, 0);
        id_use_rt = 1'b1;
        #2;
        chk("rt_used_stall", stall, 1);
        id_rs = 5'd3;
        #2;
        chk("rs_rt_both_stall", stall, 1);
        flush();

        // ---- reset mid-stream with r7 in WB
        issue(5'd7, 1'b0);
        alu_result = 32'h70;
        step();
        issue(5'd6, 1'b0);
        step();
        issue(5'd5, 1'b0);
        step();
        idle();
        #2;
        chk("mid_pre_we", write_enable, 1);
        chk("mid_pre_addr", add_C, 7);
        mem_wait = 1'b1;
        reset    = 1'b0;
        #1;
        chk("mid_rst_we", write_enable, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_alu_en", warp_ALU_enable, 0);
        chk("mid_rst_mem_en", warp_MEM_enable, 0);
        step();
        mem_wait = 1'b0;
        reset    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #2;
            chk("mid_after_we", write_enable, 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
